// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc: ID-stage hazard controller for the 5-stage MIPS core.
// Combinational forwarding selects and stall/flush controls, plus a
// multi-cycle HI/LO busy tracker and a saturating stalled-cycle counter.
module hazard_unit_mc #(
  parameter int RA_W      = 5,
  parameter int MUL_LAT   = 4,
  parameter int DIV_LAT   = 33,
  parameter int BR_FWD_EX = 0,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic             id_rs_rd,
  input  logic             id_rt_rd,
  input  logic             id_is_br,
  input  logic             id_br_taken,
  input  logic             id_md_start,
  input  logic             id_md_div,
  input  logic             id_hilo_acc,
  input  logic             ex_wr_en,
  input  logic [RA_W-1:0]  ex_wr_addr,
  input  logic             ex_is_load,
  input  logic             me_wr_en,
  input  logic [RA_W-1:0]  me_wr_addr,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             bubble_idex,
  output logic             flush_ifid,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int MD_MAX = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int MD_W   = $clog2(MD_MAX + 1);

  // Forwarding encoding: ALU result in EX wins over ME; a load in EX has
  // no data yet, so it falls through to ME (the stall covers that case).
  function automatic logic [1:0] fwd_sel(input logic hit_e, input logic hit_m,
                                         input logic e_load);
    if (hit_e && !e_load) return 2'd1;
    else if (hit_m)       return 2'd2;
    else                  return 2'd0;
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic            live_a, live_b;
  logic            hit_e_a, hit_e_b, hit_m_a, hit_m_b;
  logic            load_use, br_ex, md_hz, stall, fire;
  logic [MD_W-1:0] md_cnt_q, md_cnt_d;
  logic            md_done_q, md_done_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Dependence detection and stall/forward decisions for the ID instruction.
  always_comb begin
    live_a  = id_valid && id_rs_rd && (id_rs != '0);
    live_b  = id_valid && id_rt_rd && (id_rt != '0);
    hit_e_a = live_a && ex_wr_en && (ex_wr_addr == id_rs);
    hit_e_b = live_b && ex_wr_en && (ex_wr_addr == id_rt);
    hit_m_a = live_a && me_wr_en && (me_wr_addr == id_rs);
    hit_m_b = live_b && me_wr_en && (me_wr_addr == id_rt);

    load_use = (hit_e_a || hit_e_b) && ex_is_load;
    br_ex    = id_is_br && (hit_e_a || hit_e_b) && !ex_is_load && (BR_FWD_EX == 0);
    md_hz    = md_busy && (id_md_start || id_hilo_acc);
    stall    = load_use || br_ex || md_hz;
    fire     = id_valid && !stall;

    fwd_a_sel   = fwd_sel(hit_e_a, hit_m_a, ex_is_load);
    fwd_b_sel   = fwd_sel(hit_e_b, hit_m_b, ex_is_load);
    stall_pc    = stall;
    stall_ifid  = stall;
    bubble_idex = stall;
    // A stalled branch re-resolves next cycle, so it must not squash yet.
    flush_ifid  = id_valid && id_br_taken && !stall;
  end

  // HI/LO occupancy countdown; a start can only fire while the unit is idle.
  always_comb begin
    md_cnt_d  = md_cnt_q;
    md_done_d = 1'b0;
    if (md_cnt_q != '0) begin
      md_cnt_d  = md_cnt_q - MD_W'(1);
      md_done_d = (md_cnt_q == MD_W'(1));
    end
    if (fire && id_md_start) begin
      md_cnt_d = id_md_div ? MD_W'(DIV_LAT) : MD_W'(MUL_LAT);
    end
  end

  // Stalled-cycle counter next state.
  always_comb begin
    stall_cnt_d = stall ? sat_inc(stall_cnt_q) : stall_cnt_q;
  end

  // State registers; reset abandons any in-flight mul/div without md_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_cnt_q    <= '0;
      md_done_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      md_cnt_q    <= md_cnt_d;
      md_done_q   <= md_done_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign md_busy      = (md_cnt_q != '0);
  assign md_done      = md_done_q;
  assign stall_cycles = stall_cnt_q;

endmodule
